// File: rtl/cp0_pkg.sv
// ----------------------------------------------------------------------------
// cp0_pkg
// Shared definitions for the coprocessor-0 interrupt controller:
//   - CP0 register numbers (Status 12, Cause 13, EPC 14)
//   - Status / Cause bit-field positions
//   - sequencer state encoding
//   - default interrupt handler vector
//   - helper that packs the architecturally visible Status word
// ----------------------------------------------------------------------------
package cp0_pkg;

  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  // Status fields
  localparam int ST_IE_BIT   = 0;
  localparam int ST_EXL_BIT  = 1;
  localparam int ST_IM_LSB   = 8;
  localparam int ST_IM_MSB   = 15;

  // Cause fields
  localparam int CAUSE_IP_LSB = 10;
  localparam int CAUSE_IP_MSB = 15;

  // Hardware interrupt lines map onto IM[15:10], i.e. im[7:2] of the stored field
  localparam int IM_HW_LSB = CAUSE_IP_LSB - ST_IM_LSB;

  localparam logic [31:0] CP0_DEFAULT_VECTOR = 32'h0000_4180;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TAKE   = 2'd1,
    ST_RET    = 2'd2,
    ST_REFILL = 2'd3
  } cp0_state_e;

  // Pack Status; every bit outside IE/EXL/IM reads as zero.
  function automatic logic [31:0] status_word(input logic ie, input logic exl,
                                              input logic [7:0] im);
    logic [31:0] w;
    w                        = 32'd0;
    w[ST_IE_BIT]             = ie;
    w[ST_EXL_BIT]            = exl;
    w[ST_IM_MSB:ST_IM_LSB]   = im;
    return w;
  endfunction

endpackage

// File: rtl/cp0_int_ctrl_irq_sync.sv
// ----------------------------------------------------------------------------
// irq_sync
// WIDTH-wide two-flop synchronizer for asynchronous interrupt request levels.
// Only instantiated by cp0_int_ctrl when CP0_IRQ_SYNC_EN is defined.
// Ports:
//   clk      in  1      sampling clock
//   rst_n    in  1      asynchronous active-low reset (both stages clear to 0)
//   async_i  in  WIDTH  raw request levels
//   sync_o   out WIDTH  synchronized levels, two clocks later
// ----------------------------------------------------------------------------
module irq_sync #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two-stage capture chain; first stage may go metastable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= {WIDTH{1'b0}};
      sync_q <= {WIDTH{1'b0}};
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/cp0_int_ctrl.sv
// ----------------------------------------------------------------------------
// cp0_int_ctrl
// Coprocessor-0 register file (Status/Cause/EPC) plus the interrupt-entry and
// ERET sequencer of the 5-stage pipeline. Lives beside ID: consumes forwarded
// mtc0 data, supplies mfc0 read data, and drives flush / PC redirect.
//
// Configuration macro: CP0_IRQ_SYNC_EN
//   defined   : hw_int passes a 2-flop synchronizer before Cause.IP (3 cycles pin->IP)
//   undefined : hw_int is registered straight into Cause.IP (1 cycle)
//
// Ports:
//   clk, rst_n      clock (rising edge), async active-low reset
//   hw_int          level-sensitive interrupt requests
//   stall           pipeline frozen this cycle
//   valid_id        ID holds a real instruction
//   pc_id           PC of the ID instruction
//   mtc0_id/mfc0_id/eret_id   ID instruction decode
//   cp0_addr        CP0 register number
//   wdata           forwarded mtc0 data
//   rdata           mfc0 read data (combinational)
//   irq_flush       flush IF/ID and ID/EX (registered)
//   pc_redirect     select pc_target at the PC mux (registered)
//   pc_target       redirect PC (registered)
//   exl             Status.EXL
// ----------------------------------------------------------------------------
module cp0_int_ctrl
  import cp0_pkg::*;
#(
  parameter int          NUM_IRQ    = 6,
  parameter logic [31:0] VECTOR     = CP0_DEFAULT_VECTOR,
  parameter int          REFILL_CYC = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] hw_int,
  input  logic               stall,
  input  logic               valid_id,
  input  logic [31:0]        pc_id,
  input  logic               mtc0_id,
  input  logic               mfc0_id,
  input  logic               eret_id,
  input  logic [4:0]         cp0_addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               irq_flush,
  output logic               pc_redirect,
  output logic [31:0]        pc_target,
  output logic               exl
);

  localparam logic [2:0] REFILL_LOAD = 3'(REFILL_CYC - 1);

  logic [NUM_IRQ-1:0] hw_s;
  logic [NUM_IRQ-1:0] ip_q;
  logic [5:0]         ip_full_s;

  logic               ie_q,  ie_d;
  logic               exl_q, exl_d;
  logic [7:0]         im_q,  im_d;
  logic [31:0]        epc_q, epc_d;

  cp0_state_e         state_q, state_d;
  logic [2:0]         cnt_q,   cnt_d;

  logic               irq_flush_q, pc_redirect_q;
  logic [31:0]        pc_target_q;
  logic               redirect_d;
  logic [31:0]        target_d;

  logic               accept_s;
  logic               irq_req_s;
  logic               take_s;
  logic               ret_s;
  logic               mtc0_we_s;

`ifdef CP0_IRQ_SYNC_EN
  irq_sync #(.WIDTH(NUM_IRQ)) u_irq_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (hw_int),
    .sync_o  (hw_s)
  );
`else
  assign hw_s = hw_int;
`endif

  // Widen IP to the full 6-bit Cause field; missing lines read as zero.
  always_comb begin
    ip_full_s              = 6'd0;
    ip_full_s[NUM_IRQ-1:0] = ip_q;
  end

  assign accept_s  = valid_id & ~stall;
  assign irq_req_s = ie_q & ~exl_q &
                     (|(ip_full_s & im_q[7:IM_HW_LSB]));

  // Sequencer next state; ERET is checked first so it wins over an interrupt.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    take_s  = 1'b0;
    ret_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s && eret_id) begin
          state_d = ST_RET;
          ret_s   = 1'b1;
        end else if (accept_s && irq_req_s) begin
          state_d = ST_TAKE;
          take_s  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_TAKE, ST_RET: begin
        if (stall) begin
          state_d = state_q;
        end else begin
          state_d = ST_REFILL;
          cnt_d   = REFILL_LOAD;
        end
      end
      ST_REFILL: begin
        if (stall) begin
          cnt_d = cnt_q;
        end else if (cnt_q == 3'd0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // A taken interrupt squashes the ID instruction, including its mtc0 write.
  assign mtc0_we_s = mtc0_id & accept_s & ~take_s;

  // CP0 register next values.
  always_comb begin
    ie_d  = ie_q;
    exl_d = exl_q;
    im_d  = im_q;
    epc_d = epc_q;
    if (take_s) begin
      epc_d = pc_id;
      exl_d = 1'b1;
    end else if (mtc0_we_s) begin
      case (cp0_addr)
        CP0_STATUS: begin
          ie_d  = wdata[ST_IE_BIT];
          exl_d = wdata[ST_EXL_BIT];
          im_d  = wdata[ST_IM_MSB:ST_IM_LSB];
        end
        CP0_EPC: begin
          epc_d = wdata;
        end
        default: begin
          epc_d = epc_q;
        end
      endcase
    end else begin
      epc_d = epc_q;
    end
    if (ret_s) begin
      exl_d = 1'b0;
    end else begin
      ie_d = ie_d;
    end
  end

  // Redirect outputs follow the state being entered, so they appear one
  // cycle after the accepting edge and hold while the pipeline is stalled.
  always_comb begin
    redirect_d = 1'b0;
    target_d   = 32'd0;
    case (state_d)
      ST_TAKE: begin
        redirect_d = 1'b1;
        target_d   = VECTOR;
      end
      ST_RET: begin
        redirect_d = 1'b1;
        target_d   = epc_q;
      end
      default: begin
        redirect_d = 1'b0;
        target_d   = 32'd0;
      end
    endcase
  end

  // mfc0 read mux; no bypass of a same-cycle write.
  always_comb begin
    rdata = 32'd0;
    if (mfc0_id) begin
      case (cp0_addr)
        CP0_STATUS: rdata = status_word(ie_q, exl_q, im_q);
        CP0_CAUSE:  rdata[CAUSE_IP_MSB:CAUSE_IP_LSB] = ip_full_s;
        CP0_EPC:    rdata = epc_q;
        default:    rdata = 32'd0;
      endcase
    end else begin
      rdata = 32'd0;
    end
  end

  // State, CP0 registers, IP sampling and registered redirect outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 3'd0;
      ip_q          <= {NUM_IRQ{1'b0}};
      ie_q          <= 1'b0;
      exl_q         <= 1'b0;
      im_q          <= 8'd0;
      epc_q         <= 32'd0;
      irq_flush_q   <= 1'b0;
      pc_redirect_q <= 1'b0;
      pc_target_q   <= 32'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ip_q          <= hw_s;
      ie_q          <= ie_d;
      exl_q         <= exl_d;
      im_q          <= im_d;
      epc_q         <= epc_d;
      irq_flush_q   <= redirect_d;
      pc_redirect_q <= redirect_d;
      pc_target_q   <= target_d;
    end
  end

  assign irq_flush   = irq_flush_q;
  assign pc_redirect = pc_redirect_q;
  assign pc_target   = pc_target_q;
  assign exl         = exl_q;

endmodule
